// File: rtl/quad_input_filter.sv
// Quadrature pin conditioner: per-pin synchroniser + stability filter, then step/dir/err decode.
// Define QIF_ERR_CNT_EN to build the saturating illegal-transition counter (err_cnt/err_clr).
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A_in,
  input  logic       B_in,
  input  logic       err_clr,
  output logic       A,
  output logic       B,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic       armed,
  output logic [7:0] err_cnt
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FILT_W-1:0] CNT_LIM  = FILT_W'(FILT_LEN - 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [FILT_W-1:0]      cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic a_q, a_d, b_q, b_d, pa_q, pa_d, pb_q, pb_d;
  logic step_q, step_d, dir_q, dir_d, err_q, err_d, armed_q, armed_d;
  logic s_a, s_b, ch_a, ch_b, warm_done;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign s_a       = sync_a_q[SYNC_STAGES-1];
  assign s_b       = sync_b_q[SYNC_STAGES-1];
  assign ch_a      = a_q ^ pa_q;
  assign ch_b      = b_q ^ pb_q;
  assign warm_done = (warm_q == WARM_MAX);

  always_comb begin
    sync_a_d = {sync_a_q[SYNC_STAGES-2:0], A_in};
    sync_b_d = {sync_b_q[SYNC_STAGES-2:0], B_in};
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    if (s_a == a_q) begin
      cnt_a_d = '0;
    end else if (cnt_a_q == CNT_LIM) begin
      a_d     = s_a;
      cnt_a_d = '0;
    end else begin
      cnt_a_d = cnt_a_q + FILT_W'(1);
    end
    if (s_b == b_q) begin
      cnt_b_d = '0;
    end else if (cnt_b_q == CNT_LIM) begin
      b_d     = s_b;
      cnt_b_d = '0;
    end else begin
      cnt_b_d = cnt_b_q + FILT_W'(1);
    end
  end

  // The compare only means something once real pin samples have reached the last sync
  // stage; arming earlier would let reset zeros "match" and expose a power-up double edge.
  always_comb begin
    pa_d    = a_q;
    pb_d    = b_q;
    warm_d  = warm_done ? warm_q : warm_q + WARM_W'(1);
    armed_d = armed_q | (warm_done & (s_a == a_q) & (s_b == b_q));
    step_d  = armed_q & (ch_a ^ ch_b);
    err_d   = armed_q & ch_a & ch_b;
    // Forward order 00->10->11->01 reduces to new A differing from old B.
    dir_d   = step_d ? (a_q ^ pb_q) : dir_q;
  end

`ifdef QIF_ERR_CNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_q && (err_cnt_q != 8'd255)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end
  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt_d      = 8'd0;
  assign err_cnt        = 8'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q  <= '0;
      sync_b_q  <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      warm_q    <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      pa_q      <= 1'b0;
      pb_q      <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      armed_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      warm_q    <= warm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      armed_q   <= armed_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;
  assign armed = armed_q;

endmodule
